// File: rtl/cntr_nud_pkg.sv
// Shared constants for the cntr_nud up/down counter.
// Optional saturate mode is compiled in with the CNTR_NUD_SAT_EN macro.
package cntr_nud_pkg;

    // Direction encoding on up_down
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Bound behaviour encoding on sat_mode
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Legal range of the WIDTH parameter
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/cntr_nud_next.sv
// Combinational next-state function of cntr_nud: the stepped count, its wrap
// flag and the terminal-count output. It knows nothing about reset or load.
// Saturate logic exists only when CNTR_NUD_SAT_EN is defined.
module cntr_nud_next
    import cntr_nud_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] max_val,
    input  logic             en,
    input  logic             up_down,
`ifdef CNTR_NUD_SAT_EN
    input  logic             sat_mode,
`endif
    output logic [WIDTH-1:0] next_count,
    output logic             next_wrap,
    output logic             tc
);

    // tc flags that the next enabled step hits a bound (wrap or hold)
    assign tc = en & ((up_down == DIR_DOWN) ? (count == '0) : (count >= max_val));

    // Result of one step in the selected direction; a count above max_val
    // (after max_val was lowered) wraps to 0 going up and clamps going down
    always_comb begin
        next_count = count;
        next_wrap  = 1'b0;
        if (up_down == DIR_UP) begin
            if (count >= max_val) begin
`ifdef CNTR_NUD_SAT_EN
                if (sat_mode == MODE_SAT) begin
                    next_count = max_val;
                end else begin
                    next_count = '0;
                    next_wrap  = 1'b1;
                end
`else
                next_count = '0;
                next_wrap  = 1'b1;
`endif
            end else begin
                next_count = count + WIDTH'(1);
            end
        end else begin
            if (count == '0) begin
`ifdef CNTR_NUD_SAT_EN
                if (sat_mode == MODE_SAT) begin
                    next_count = '0;
                end else begin
                    next_count = max_val;
                    next_wrap  = 1'b1;
                end
`else
                next_count = max_val;
                next_wrap  = 1'b1;
`endif
            end else if (count > max_val) begin
                next_count = max_val;
            end else begin
                next_count = count - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/cntr_nud.sv
// Parametrised up/down counter with programmable modulus, synchronous load,
// count enable, terminal-count and wrap-event outputs.
// Define CNTR_NUD_SAT_EN to add the sat_mode port and saturate behaviour.
module cntr_nud
    import cntr_nud_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
`ifdef CNTR_NUD_SAT_EN
    input  logic             sat_mode,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("cntr_nud: WIDTH out of legal range");
    end

    logic [WIDTH-1:0] step_count;
    logic             step_wrap;
    logic [WIDTH-1:0] load_clamped;

    cntr_nud_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .count      (count),
        .max_val    (max_val),
        .en         (en),
        .up_down    (up_down),
`ifdef CNTR_NUD_SAT_EN
        .sat_mode   (sat_mode),
`endif
        .next_count (step_count),
        .next_wrap  (step_wrap),
        .tc         (tc)
    );

    // A loaded value never lands outside the count range
    assign load_clamped = (load_val > max_val) ? max_val : load_val;

    // Priority mux reset > load > en > hold; wrap is a one-cycle pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            wrap  <= 1'b0;
        end else if (en) begin
            count <= step_count;
            wrap  <= step_wrap;
        end else begin
            wrap  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cntr_nud.sv
// Self-checking bench for cntr_nud at WIDTH=4: directed scenarios followed by
// randomized traffic compared against an arithmetic reference model.
module tb_cntr_nud;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         up_down;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] max_val;
`ifdef CNTR_NUD_SAT_EN
    logic         sat_mode = 1'b0;
`endif
    logic [W-1:0] count;
    logic         tc;
    logic         wrap;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cntr_nud #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up_down  (up_down),
        .load     (load),
        .load_val (load_val),
        .max_val  (max_val),
`ifdef CNTR_NUD_SAT_EN
        .sat_mode (sat_mode),
`endif
        .count    (count),
        .tc       (tc),
        .wrap     (wrap)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; en = 1'b0; up_down = 1'b0; load = 1'b0;
        load_val = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic do_load(input int v, input int m);
        idle_inputs();
        max_val = W'(m); load_val = W'(v); load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        max_val = 4'd9; en = 1'b1; load = 1'b1; load_val = 4'd7;
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (count !== 4'd0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset: count=%0d wrap=%0b, required count=0 wrap=0", count, wrap);
        end
        reset = 1'b0; en = 1'b0; load = 1'b0;
        #1;
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("FAIL reset_tc: tc=%0b, required 0", tc);
        end
    endtask

    task automatic test_up_wrap();
        int cur = 0;
        do_reset();
        max_val = 4'd9; en = 1'b1; up_down = 1'b0;
        for (int i = 0; i < 12; i++) begin
            int nxt;
            #1;
            checks++;
            if (tc !== (cur == 9)) begin
                errors++;
                $display("FAIL up_tc[%0d]: tc=%0b at count=%0d, required %0b", i, tc, cur, cur == 9);
            end
            nxt = (cur == 9) ? 0 : cur + 1;
            tick();
            checks++;
            if (count !== W'(nxt) || wrap !== (cur == 9)) begin
                errors++;
                $display("FAIL up_wrap[%0d]: count=%0d wrap=%0b, required count=%0d wrap=%0b",
                         i, count, wrap, nxt, cur == 9);
            end
            cur = nxt;
        end
        en = 1'b0;
    endtask

    task automatic test_down_wrap();
        int exp_seq[5] = '{9, 8, 7, 6, 5};
        int cur = 0;
        do_reset();
        max_val = 4'd9; en = 1'b1; up_down = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (tc !== (cur == 0)) begin
                errors++;
                $display("FAIL down_tc[%0d]: tc=%0b, required %0b", i, tc, cur == 0);
            end
            tick();
            checks++;
            if (count !== W'(exp_seq[i]) || wrap !== (i == 0)) begin
                errors++;
                $display("FAIL down_wrap[%0d]: count=%0d wrap=%0b, required count=%0d wrap=%0b",
                         i, count, wrap, exp_seq[i], i == 0);
            end
            cur = exp_seq[i];
        end
        en = 1'b0;
    endtask

    task automatic test_load_priority();
        do_reset();
        max_val = 4'd5; load = 1'b1; load_val = 4'd12; en = 1'b1; up_down = 1'b0;
        tick();
        checks++;
        if (count !== 4'd5 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL load_clamp: count=%0d wrap=%0b, required count=5 wrap=0", count, wrap);
        end
        reset = 1'b1; load = 1'b1; load_val = 4'd3;
        tick();
        checks++;
        if (count !== 4'd0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_over_load: count=%0d wrap=%0b, required count=0 wrap=0", count, wrap);
        end
        idle_inputs();
    endtask

    task automatic test_modulus_lowered();
        do_load(8, 9);
        max_val = 4'd3; en = 1'b1; up_down = 1'b0;
        #1;
        checks++;
        if (tc !== 1'b1) begin
            errors++;
            $display("FAIL lowered_up_tc: tc=%0b, required 1", tc);
        end
        tick();
        checks++;
        if (count !== 4'd0 || wrap !== 1'b1) begin
            errors++;
            $display("FAIL lowered_up: count=%0d wrap=%0b, required count=0 wrap=1", count, wrap);
        end
        do_load(8, 9);
        max_val = 4'd3; en = 1'b1; up_down = 1'b1;
        tick();
        checks++;
        if (count !== 4'd3 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL lowered_down: count=%0d wrap=%0b, required count=3 wrap=0", count, wrap);
        end
        idle_inputs();
    endtask

    task automatic test_direction();
        int exp_seq[3] = '{5, 4, 5};
        do_load(4, 9);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            up_down = (i % 2 == 1);
            tick();
            checks++;
            if (count !== W'(exp_seq[i])) begin
                errors++;
                $display("FAIL direction[%0d]: count=%0d, required %0d", i, count, exp_seq[i]);
            end
        end
        en = 1'b0; up_down = 1'b0;
        #1;
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("FAIL hold_tc: tc=%0b, required 0", tc);
        end
        tick();
        tick();
        checks++;
        if (count !== 4'd5 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL hold: count=%0d wrap=%0b, required count=5 wrap=0", count, wrap);
        end
    endtask

    task automatic test_max_zero();
        do_reset();
        max_val = 4'd0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_down = (i >= 2);
            tick();
            checks++;
            if (count !== 4'd0 || wrap !== 1'b1) begin
                errors++;
                $display("FAIL max_zero[%0d]: count=%0d wrap=%0b, required count=0 wrap=1", i, count, wrap);
            end
        end
        idle_inputs();
    endtask

    task automatic test_saturate();
`ifdef CNTR_NUD_SAT_EN
        sat_mode = 1'b1;
        do_load(6, 7);
        en = 1'b1; up_down = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (count !== 4'd7 || wrap !== 1'b0) begin
                errors++;
                $display("FAIL sat_up[%0d]: count=%0d wrap=%0b, required count=7 wrap=0", i, count, wrap);
            end
        end
        checks++;
        if (tc !== 1'b1) begin
            errors++;
            $display("FAIL sat_tc: tc=%0b, required 1", tc);
        end
        do_load(1, 7);
        en = 1'b1; up_down = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (count !== 4'd0 || wrap !== 1'b0) begin
                errors++;
                $display("FAIL sat_down[%0d]: count=%0d wrap=%0b, required count=0 wrap=0", i, count, wrap);
            end
        end
        sat_mode = 1'b0;
        idle_inputs();
`else
        do_load(6, 7);
        en = 1'b1; up_down = 1'b0;
        tick();
        checks++;
        if (count !== 4'd7 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL wrap7_a: count=%0d wrap=%0b, required count=7 wrap=0", count, wrap);
        end
        tick();
        checks++;
        if (count !== 4'd0 || wrap !== 1'b1) begin
            errors++;
            $display("FAIL wrap7_b: count=%0d wrap=%0b, required count=0 wrap=1", count, wrap);
        end
        idle_inputs();
`endif
    endtask

    // Reference: the count lives on a ring of max+1 positions; values above
    // max only arise after max is lowered.
    task automatic test_random();
        int m_count = 0;
        int m_wrap  = 0;
        int mx, c, nc, nw, sat, exp_tc;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 99) < 2);
            load     = ($urandom_range(0, 99) < 8);
            en       = ($urandom_range(0, 99) < 75);
            up_down  = $urandom_range(0, 1);
            load_val = W'($urandom);
            if ($urandom_range(0, 9) == 0) max_val = W'($urandom);
            sat = 0;
`ifdef CNTR_NUD_SAT_EN
            sat_mode = ($urandom_range(0, 3) == 0);
            sat = sat_mode;
`endif
            mx = int'(max_val);
            c  = m_count;
            #1;
            exp_tc = en && (up_down ? (c == 0) : (c >= mx));
            checks++;
            if (tc !== exp_tc[0]) begin
                errors++;
                $display("FAIL rand_tc[%0d]: tc=%0b, required %0b", i, tc, exp_tc[0]);
            end
            nc = c; nw = 0;
            if (reset) begin
                nc = 0;
            end else if (load) begin
                nc = (int'(load_val) < mx) ? int'(load_val) : mx;
            end else if (en) begin
                if (!up_down) begin
                    if (c >= mx && sat != 0) nc = mx;
                    else begin
                        nc = (c > mx) ? 0 : (c + 1) % (mx + 1);
                        nw = (c >= mx);
                    end
                end else begin
                    if (c == 0 && sat != 0) nc = 0;
                    else begin
                        nc = (c > mx) ? mx : (c + mx) % (mx + 1);
                        nw = (c == 0);
                    end
                end
            end
            m_count = nc; m_wrap = nw;
            tick();
            checks++;
            if (count !== W'(m_count) || wrap !== m_wrap[0]) begin
                errors++;
                $display("FAIL rand[%0d]: count=%0d wrap=%0b, required count=%0d wrap=%0b",
                         i, count, wrap, m_count, m_wrap[0]);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        max_val = '0;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load_priority();
        test_modulus_lowered();
        test_direction();
        test_max_zero();
        test_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
